// File: rtl/axi4_lite_regs_slave_if.sv
// AXI4-Lite channel bundle between the PS general-purpose port (master) and the
// register strobe bridge (slave).
interface axi4_lite_regs_slave_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  // Every channel transfers on a cycle where VALID and READY are both high.
  // VALID, once raised, stays up with stable payload until that cycle.
  logic [AW-1:0]   S_AXI_AWADDR;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_regs_slave.sv
// AXI4-Lite slave turning each write into a one-cycle set_stb and each read into
// a one-cycle get_stb, with independent write and read state machines.
module axi4_lite_regs_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  axi4_lite_regs_slave_if.slave         s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] set_data,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr,
  output logic                          set_stb,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr,
  output logic                          get_stb,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] get_data,
  output logic [1:0]                    w_state_dbg,
  output logic [1:0]                    r_state_dbg
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_STB = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_STB = 2'd1, R_CAP = 2'd2, R_RESP = 2'd3} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic          arready_q, rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          aw_held, w_held;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  logic          aw_hs, w_hs, ar_hs, have_aw, have_w;
  logic [AW-1:0] awaddr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [SW-1:0] wstrb_nxt;

  assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs  = s_axi.S_AXI_WVALID & wready_q;
  assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;
  assign have_aw = aw_held | aw_hs;
  assign have_w  = w_held | w_hs;

  // The second of AW/W may arrive on the very edge we leave W_IDLE, so the
  // strobe payload comes from the bus when it has not been latched yet.
  assign awaddr_nxt = aw_held ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign wdata_nxt  = w_held  ? wdata_q  : s_axi.S_AXI_WDATA;
  assign wstrb_nxt  = w_held  ? wstrb_q  : s_axi.S_AXI_WSTRB;

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;
  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      set_stb   <= 1'b0;
      set_addr  <= '0;
      set_data  <= '0;
    end else begin
      set_stb <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q <= s_axi.S_AXI_AWADDR;
            aw_held  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= s_axi.S_AXI_WDATA;
            wstrb_q <= s_axi.S_AXI_WSTRB;
            w_held  <= 1'b1;
          end
          awready_q <= ~have_aw;
          wready_q  <= ~have_w;
          if (have_aw && have_w) begin
            w_state <= W_STB;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            // Partial-strobe writes are refused outright rather than merged.
            if (&wstrb_nxt) begin
              set_stb  <= 1'b1;
              set_addr <= awaddr_nxt;
              set_data <= wdata_nxt;
            end
          end
        end
        W_STB: begin
          bresp_q  <= (&wstrb_q) ? RESP_OKAY : RESP_SLVERR;
          bvalid_q <= 1'b1;
          w_state  <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // The register bank answers one cycle after get_stb; R_CAP samples it then.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      get_stb   <= 1'b0;
      get_addr  <= '0;
    end else begin
      get_stb <= 1'b0;
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            get_addr  <= s_axi.S_AXI_ARADDR;
            arready_q <= 1'b0;
            get_stb   <= 1'b1;
            r_state   <= R_STB;
          end
        end
        R_STB: r_state <= R_CAP;
        R_CAP: begin
          rdata_q  <= get_data;
          rvalid_q <= 1'b1;
          r_state  <= R_RESP;
        end
        R_RESP: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_regs_slave.sv
// Bench for axi4_lite_regs_slave: directed cases then randomized traffic,
// checked against a word-array model of the register bank and strobe timing.
module tb_axi4_lite_regs_slave;
  logic        clk;
  logic        rst;
  logic [31:0] set_data, set_addr, get_addr, get_data;
  logic        set_stb, get_stb;
  logic [1:0]  w_state_dbg, r_state_dbg;

  axi4_lite_regs_slave_if #(.AW(32), .DW(32)) axi ();

  axi4_lite_regs_slave #(.C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s_axi(axi.slave),
    .set_data(set_data), .set_addr(set_addr), .set_stb(set_stb),
    .get_addr(get_addr), .get_stb(get_stb), .get_data(get_data),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // register bank responder and reference model
  logic [31:0] bank [16];
  logic [31:0] exp_bank [16];
  logic        bank_hit;
  logic [3:0]  bank_idx;

  always begin
    @(negedge clk);
    bank_hit = get_stb;
    bank_idx = get_addr[5:2];
    if (set_stb === 1'b1) bank[set_addr[5:2]] = set_data;
    @(posedge clk);
    #1;
    get_data = (bank_hit === 1'b1) ? bank[bank_idx] : $urandom;
  end

  // scoreboard
  logic [63:0] exp_q [$];
  int          exp_cyc_q [$];
  logic [31:0] exp_r_q [$];
  int          exp_rc_q [$];
  int          last_set_cyc = -1;
  int          last_get_cyc = -1;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst === 1'b1 && set_stb !== 1'b0) begin
      if (exp_q.size() == 0) check("set_stb_unexpected", {63'd0, set_stb}, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("set_addr", {32'd0, set_addr}, {32'd0, e[63:32]});
        check("set_data", {32'd0, set_data}, {32'd0, e[31:0]});
        check("set_stb_cycle", cyc, exp_cyc_q.pop_front());
      end
      last_set_cyc = cyc;
    end
    if (rst === 1'b1 && get_stb !== 1'b0) begin
      if (exp_r_q.size() == 0) check("get_stb_unexpected", {63'd0, get_stb}, 64'd0);
      else begin
        check("get_addr", {32'd0, get_addr}, {32'd0, exp_r_q.pop_front()});
        check("get_stb_cycle", cyc, exp_rc_q.pop_front());
      end
      last_get_cyc = cyc;
    end
  end

  // driver tasks (entered and left just after a falling edge)
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, b_seen = 0, done = 0;
    int n = 0, bn = 0, t_both = 0;
    axi.S_AXI_AWADDR = a;
    axi.S_AXI_WDATA  = d;
    axi.S_AXI_WSTRB  = s;
    while (!(aw_done && w_done) && n < 50) begin
      if (w_done) check("wready_after_w", {63'd0, axi.S_AXI_WREADY}, 64'd0);
      axi.S_AXI_AWVALID = !aw_done && n >= aw_dly;
      axi.S_AXI_WVALID  = !w_done && n >= w_dly;
      if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) aw_done = 1;
      if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) w_done = 1;
      if (aw_done && w_done) begin
        t_both = cyc;
        if (s == 4'hF) begin
          exp_q.push_back({a, d});
          exp_cyc_q.push_back(cyc + 1);
          exp_bank[a[5:2]] = d;
        end
      end
      n++;
      @(negedge clk);
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("wr_addr_data_accepted", {62'd0, aw_done, w_done}, 64'd3);
    n = 0;
    while (!done && n < 60) begin
      if (axi.S_AXI_BVALID && !b_seen) begin
        b_seen = 1;
        check("b_latency", cyc, t_both + 2);
      end
      if (b_seen) begin
        check("bvalid_held", {63'd0, axi.S_AXI_BVALID}, 64'd1);
        axi.S_AXI_BREADY = (bn >= b_dly);
        if (axi.S_AXI_BREADY) begin
          check("bresp", {62'd0, axi.S_AXI_BRESP}, (s == 4'hF) ? 64'd0 : 64'd2);
          done = 1;
        end else begin
          check("wr_ready_low_in_b", {62'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 64'd0);
        end
        bn++;
      end
      n++;
      @(negedge clk);
    end
    axi.S_AXI_BREADY = 1'b0;
    check("b_completed", {63'd0, done}, 64'd1);
    check("wr_strobe_queue_drained", exp_q.size(), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly);
    bit ar_done = 0, r_seen = 0, done = 0;
    int n = 0, rn = 0, t_ar = 0;
    logic [31:0] exp_d;
    axi.S_AXI_ARADDR = a;
    while (!ar_done && n < 50) begin
      axi.S_AXI_ARVALID = 1'b1;
      if (axi.S_AXI_ARREADY) begin
        ar_done = 1;
        t_ar = cyc;
        exp_r_q.push_back(a);
        exp_rc_q.push_back(cyc + 1);
      end
      n++;
      @(negedge clk);
    end
    axi.S_AXI_ARVALID = 1'b0;
    check("ar_accepted", {63'd0, ar_done}, 64'd1);
    exp_d = exp_bank[a[5:2]];
    n = 0;
    while (!done && n < 60) begin
      if (axi.S_AXI_RVALID && !r_seen) begin
        r_seen = 1;
        check("r_latency", cyc, t_ar + 3);
      end
      if (r_seen) begin
        check("rvalid_held", {63'd0, axi.S_AXI_RVALID}, 64'd1);
        check("rdata", {32'd0, axi.S_AXI_RDATA}, {32'd0, exp_d});
        axi.S_AXI_RREADY = (rn >= r_dly);
        if (axi.S_AXI_RREADY) begin
          check("rresp", {62'd0, axi.S_AXI_RRESP}, 64'd0);
          done = 1;
        end else begin
          check("arready_low_in_r", {63'd0, axi.S_AXI_ARREADY}, 64'd0);
        end
        rn++;
      end
      n++;
      @(negedge clk);
    end
    axi.S_AXI_RREADY = 1'b0;
    check("r_completed", {63'd0, done}, 64'd1);
    check("rd_strobe_queue_drained", exp_r_q.size(), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {53'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
          axi.S_AXI_BRESP, axi.S_AXI_ARREADY, axi.S_AXI_RVALID, axi.S_AXI_RRESP,
          set_stb, get_stb}, 64'd0);
    check({tag, "_rdata"}, {32'd0, axi.S_AXI_RDATA}, 64'd0);
    check({tag, "_fsm_idle"}, {60'd0, w_state_dbg, r_state_dbg}, 64'd0);
  endtask

  // stimulus
  initial begin
    logic [31:0] a, ra, d;
    logic [3:0]  s;
    int          op;

    rst = 1'b0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY = 1'b0;
    get_data = '0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      bank[i] = d;
      exp_bank[i] = d;
    end
    bank[1] = 32'h12345678;
    exp_bank[1] = 32'h12345678;

    // 1: reset held three cycles with AW/AR valid
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    check("reset_set_addr", {32'd0, set_addr}, 64'd0);
    check("reset_set_data", {32'd0, set_data}, 64'd0);
    check("reset_get_addr", {32'd0, get_addr}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("arready_after_reset", {63'd0, axi.S_AXI_ARREADY}, 64'd1);
    check("awready_after_reset", {63'd0, axi.S_AXI_AWREADY}, 64'd1);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_ARVALID = 1'b0;
    @(negedge clk);

    // 2: AW and W together, full strobe
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    // 3: W a cycle ahead of AW, partial strobe refused
    do_write(32'hC, 32'hCAFEF00D, 4'h3, 1, 0, 2);
    // 4: read with a five-cycle RREADY stall
    do_read(32'h4, 5);
    // 5: write and read issued together
    fork
      do_write(32'h10, 32'hA5A55A5A, 4'hF, 0, 0, 1);
      do_read(32'h8, 0);
    join
    check("same_cycle_strobes", last_get_cyc, last_set_cyc);

    // 6: reset while write sits in W_RESP and read in R_CAP
    axi.S_AXI_AWADDR = 32'h14; axi.S_AXI_WDATA = 32'h0BADF00D; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_ARADDR = 32'h18;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_ARVALID = 1'b1;
    exp_q.push_back({32'h14, 32'h0BADF00D});
    exp_cyc_q.push_back(cyc + 1);
    exp_bank[5] = 32'h0BADF00D;
    exp_r_q.push_back(32'h18);
    exp_rc_q.push_back(cyc + 1);
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("pre_reset_bvalid", {63'd0, axi.S_AXI_BVALID}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midflight_reset");
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_midflight_reset",
          {61'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 64'd7);
    check("valids_after_midflight_reset",
          {62'd0, axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 64'd0);
    do_write(32'h1C, 32'h13572468, 4'hF, 0, 0, 0);
    do_read(32'h14, 1);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      ra = a ^ 32'h4;
      d  = $urandom;
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (op == 0)
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op == 1)
        do_read(ra, $urandom_range(0, 3));
      else
        fork
          do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
          do_read(ra, $urandom_range(0, 3));
        join
    end

    repeat (3) @(negedge clk);
    check("final_write_queue", exp_q.size(), 64'd0);
    check("final_read_queue", exp_r_q.size(), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
